// File: rtl/and_or_monitor.sv
// Online checker for y = (a & b) | (c & d): counts passes/failures, records the
// first failing vector and tracks which of the 16 input vectors have been seen.
module and_or_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             y,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [15:0]      cov_map,
    output logic             err,
    output logic [3:0]       first_err_vec,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic and_or_exp(input logic [3:0] vec);
        return (vec[3] & vec[2]) | (vec[1] & vec[0]);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic [15:0]      cov_q, cov_d, cov_set_s;
    logic             err_q, err_d, done_q;
    logic [3:0]       first_q, first_d;
    logic [3:0]       idx_s;
    logic             accept_s, clear_s;

    assign idx_s    = {a, b, c, d};
    assign accept_s = in_valid & in_ready;
    assign clear_s  = start & (state_q != S_RUN);

    // Coverage map as it would look after accepting the current sample.
    always_comb begin
        cov_set_s        = cov_q;
        cov_set_s[idx_s] = 1'b1;
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pass_q  <= '0;
            fail_q  <= '0;
            cov_q   <= 16'h0000;
            err_q   <= 1'b0;
            first_q <= 4'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            cov_q   <= cov_d;
            err_q   <= err_d;
            first_q <= first_d;
            done_q  <= (state_d == S_DONE);
        end
    end

    // Next-state logic; the completing accept moves RUN to DONE on its own edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (accept_s && (cov_set_s == 16'hFFFF)) state_d = S_DONE;
                else                                      state_d = S_RUN;
            end
            S_DONE: begin
                if (start) state_d = S_RUN;
                else       state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: samples are only taken while running.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_RUN:   in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
    end

    // Result datapath: clear on a (re)start, otherwise update on accept.
    always_comb begin
        pass_d  = pass_q;
        fail_d  = fail_q;
        cov_d   = cov_q;
        err_d   = err_q;
        first_d = first_q;
        if (clear_s) begin
            pass_d  = '0;
            fail_d  = '0;
            cov_d   = 16'h0000;
            err_d   = 1'b0;
            first_d = 4'h0;
        end else if (accept_s) begin
            cov_d = cov_set_s;
            if (y == and_or_exp(idx_s)) begin
                if (pass_q != CNT_MAX) pass_d = pass_q + CNT_ONE;
                else                   pass_d = pass_q;
            end else begin
                if (fail_q != CNT_MAX) fail_d = fail_q + CNT_ONE;
                else                   fail_d = fail_q;
                err_d = 1'b1;
                if (!err_q) first_d = idx_s;
                else        first_d = first_q;
            end
        end else begin
            cov_d = cov_q;
        end
    end

    assign pass_cnt      = pass_q;
    assign fail_cnt      = fail_q;
    assign cov_map       = cov_q;
    assign err           = err_q;
    assign first_err_vec = first_q;
    assign done          = done_q;

endmodule

// File: tb/tb_and_or_monitor.sv
// Randomised and directed bench for and_or_monitor against a truth-table model.
module tb_and_or_monitor;

    logic clk = 1'b0;
    logic rst, start, in_valid, a, b, c, d, y;
    logic       in_ready, err, done, in_ready4, err4, done4;
    logic [7:0] pass_cnt, fail_cnt;
    logic [3:0] pass4, fail4, first_err_vec, first4;
    logic [15:0] cov_map, cov4;

    and_or_monitor #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .y(y), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .cov_map(cov_map), .err(err), .first_err_vec(first_err_vec), .done(done));

    and_or_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .c(c), .d(d), .y(y), .pass_cnt(pass4), .fail_cnt(fail4),
        .cov_map(cov4), .err(err4), .first_err_vec(first4), .done(done4));

    always #5 clk = ~clk;

    // Truth table of (a&b)|(c&d), indexed by {a,b,c,d}.
    localparam logic [15:0] TT = 16'hF888;

    int n_vec = 0, n_cmp = 0, n_miss = 0;
    int m_state = 0;            // 0 idle, 1 run, 2 done
    int m_pass = 0, m_fail = 0; // unbounded raw counts
    logic [15:0] m_cov = 16'h0000;
    logic        m_err = 1'b0;
    logic [3:0]  m_first = 4'h0;

    wire [46:0] obs = {in_ready, done, err, first_err_vec, cov_map, pass_cnt, fail_cnt, pass4, fail4};

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [46:0] expv();
        logic [7:0] p8, f8;
        logic [3:0] p4, f4;
        p8 = 8'(sat(m_pass, 255)); f8 = 8'(sat(m_fail, 255));
        p4 = 4'(sat(m_pass, 15));  f4 = 4'(sat(m_fail, 15));
        return {m_state == 1, m_state == 2, m_err, m_first, m_cov, p8, f8, p4, f4};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic apply(input logic st, input logic v, input logic [3:0] idx,
                         input logic yv, input logic r);
        rst = r; start = st; in_valid = v; {a, b, c, d} = idx; y = yv;
        @(posedge clk);
        n_vec++;
        if (r) begin
            m_state = 0; m_pass = 0; m_fail = 0; m_cov = 16'h0000; m_err = 1'b0; m_first = 4'h0;
        end else if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_pass = 0; m_fail = 0; m_cov = 16'h0000; m_err = 1'b0; m_first = 4'h0;
            end
        end else if (v) begin
            if (yv == TT[idx]) m_pass++;
            else begin
                m_fail++;
                if (!m_err) m_first = idx;
                m_err = 1'b1;
            end
            m_cov[idx] = 1'b1;
            if (m_cov == 16'hFFFF) m_state = 2;
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== 47'd0) begin
            n_miss++; $display("FAIL reset: got %h want 0", obs);
        end
    endtask

    task automatic test_exhaustive();
        apply(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, 1'b1, 4'(i), TT[i], 1'b0);
            n_cmp++;
            if (obs !== expv()) begin
                n_miss++; $display("FAIL exhaustive step %0d: got %h want %h", i, obs, expv());
            end
        end
        n_cmp++;
        if (pass_cnt !== 8'd16 || fail_cnt !== 8'd0 || cov_map !== 16'hFFFF
            || done !== 1'b1 || in_ready !== 1'b0) begin
            n_miss++;
            $display("FAIL exhaustive end: got pass=%0d fail=%0d cov=%h done=%b rdy=%b want 16 0 ffff 1 0",
                     pass_cnt, fail_cnt, cov_map, done, in_ready);
        end
        // DONE must ignore further samples, even wrong ones.
        apply(1'b0, 1'b1, 4'd2, ~TT[2], 1'b0);
        n_cmp++;
        if (fail_cnt !== 8'd0 || pass_cnt !== 8'd16 || obs !== expv()) begin
            n_miss++; $display("FAIL done_hold: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_first_error();
        apply(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            apply(1'b0, 1'b1, 4'(i), TT[i] ^ ((i == 6) || (i == 9)), 1'b0);
        n_cmp++;
        if (fail_cnt !== 8'd2 || pass_cnt !== 8'd14 || err !== 1'b1
            || first_err_vec !== 4'd6 || done !== 1'b1) begin
            n_miss++;
            $display("FAIL first_error: got fail=%0d pass=%0d err=%b first=%0d done=%b want 2 14 1 6 1",
                     fail_cnt, pass_cnt, err, first_err_vec, done);
        end
    endtask

    task automatic test_restart_from_done();
        apply(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        n_cmp++;
        if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || cov_map !== 16'h0000 || err !== 1'b0
            || first_err_vec !== 4'd0 || in_ready !== 1'b1 || done !== 1'b0) begin
            n_miss++; $display("FAIL restart: got %h want %h", obs, expv());
        end
    endtask

    task automatic test_repeat();
        for (int i = 0; i < 20; i++)
            apply(i == 10, 1'b1, 4'd3, TT[3], 1'b0);
        n_cmp++;
        if (pass_cnt !== 8'd20 || cov_map !== 16'h0008 || done !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL repeat: got pass=%0d cov=%h done=%b rdy=%b want 20 0008 0 1",
                     pass_cnt, cov_map, done, in_ready);
        end
    endtask

    task automatic test_saturation();
        apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            apply(1'b0, 1'b1, 4'd0, TT[0], 1'b0);
        n_cmp++;
        if (pass4 !== 4'd15 || fail4 !== 4'd0 || pass_cnt !== 8'd20) begin
            n_miss++;
            $display("FAIL saturation: got pass4=%0d fail4=%0d pass8=%0d want 15 0 20", pass4, fail4, pass_cnt);
        end
    endtask

    task automatic test_idle_start_valid();
        apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 4'd7, TT[7], 1'b0);
        n_cmp++;
        if (pass_cnt !== 8'd0 || cov_map !== 16'h0000 || in_ready !== 1'b1) begin
            n_miss++; $display("FAIL idle_start: got pass=%0d cov=%h rdy=%b want 0 0000 1", pass_cnt, cov_map, in_ready);
        end
        apply(1'b0, 1'b1, 4'd7, TT[7], 1'b0);
        n_cmp++;
        if (pass_cnt !== 8'd1 || cov_map !== 16'h0080) begin
            n_miss++; $display("FAIL first_accept: got pass=%0d cov=%h want 1 0080", pass_cnt, cov_map);
        end
    endtask

    task automatic test_reset_midrun();
        apply(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            apply(1'b0, 1'b1, 4'(i + 4), ~TT[i + 4], 1'b0);
        apply(1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== 47'd0) begin
            n_miss++; $display("FAIL reset_midrun: got %h want 0", obs);
        end
        for (int i = 0; i < 3; i++)
            apply(1'b0, 1'b1, 4'(i), TT[i], 1'b0);
        n_cmp++;
        if (obs !== 47'd0) begin
            n_miss++; $display("FAIL no_accept_after_reset: got %h want 0", obs);
        end
    endtask

    task automatic test_random();
        logic [3:0] idx;
        apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            idx = 4'($urandom_range(0, 15));
            apply($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, idx,
                  TT[idx] ^ ($urandom_range(0, 9) == 0), $urandom_range(0, 149) == 0);
            n_cmp++;
            if (obs !== expv()) begin
                n_miss++; $display("FAIL random cycle %0d: got %h want %h", i, obs, expv());
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; {a, b, c, d} = 4'h0; y = 1'b0;
        @(negedge clk);
        test_reset();
        test_exhaustive();
        test_first_error();
        test_restart_from_done();
        test_repeat();
        test_saturation();
        test_idle_start_valid();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
